// File: rtl/rv_timer_multi_pkg.sv
// Shared definitions for rv_timer_multi: register offsets, CTRL/CFG field layout and the cfg_t record.
package rv_timer_multi_pkg;

  typedef enum logic [11:0] {
    REG_CTRL        = 12'h000,
    REG_CFG         = 12'h004,
    REG_MTIME_LO    = 12'h008,
    REG_MTIME_HI    = 12'h00C,
    REG_INTR_ENABLE = 12'h010,
    REG_INTR_STATE  = 12'h014,
    REG_INTR_TEST   = 12'h018
  } reg_off_e;

  // Per-channel windows, selected by addr[11:8]; channel index is addr[7:3], addr[2] picks the high half
  localparam logic [3:0] CMP_PAGE = 4'h1;
  localparam logic [3:0] PRD_PAGE = 4'h2;

  localparam int unsigned CTRL_ACTIVE_BIT  = 0;
  localparam int unsigned CFG_PRESCALE_LSB = 0;
  localparam int unsigned CFG_PRESCALE_W   = 12;
  localparam int unsigned CFG_STEP_LSB     = 16;
  localparam int unsigned CFG_STEP_W       = 8;

  typedef struct packed {
    logic                      active;
    logic [CFG_PRESCALE_W-1:0] prescale;
    logic [CFG_STEP_W-1:0]     step;
  } cfg_t;

  function automatic logic [31:0] cfg_to_word(cfg_t c);
    return {8'h00, c.step, 4'h0, c.prescale};
  endfunction

endpackage

// File: rtl/rv_timer_multi_chan.sv
// One comparator channel: compare/period registers, expiry detect, sticky interrupt state.
// Periodic reload of compare is built only with RV_TIMER_MULTI_AUTORELOAD_EN defined.
module rv_timer_multi_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime,
  input  logic        cmp_we_lo,
  input  logic        cmp_we_hi,
  input  logic        prd_we_lo,
  input  logic        prd_we_hi,
  input  logic [31:0] wdata,
  input  logic        set_test,
  input  logic        clr,
  output logic [63:0] compare,
  output logic [63:0] period,
  output logic        intr_state
);

  logic [63:0] compare_q;
  logic        state_q;
  logic        expired;
  logic        reload;

  assign expired = (mtime >= compare_q);

`ifdef RV_TIMER_MULTI_AUTORELOAD_EN
  logic [63:0] period_q;

  assign reload = expired && (period_q != '0);
  assign period = period_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
    end else begin
      if (prd_we_lo) period_q[31:0]  <= wdata;
      if (prd_we_hi) period_q[63:32] <= wdata;
    end
  end
`else
  logic unused_prd;

  assign unused_prd = prd_we_lo ^ prd_we_hi;
  assign reload     = 1'b0;
  assign period     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= '1;
      state_q   <= 1'b0;
    end else begin
      // Set sources dominate the W1C clear
      state_q <= (state_q & ~clr) | expired | set_test;
      if (cmp_we_lo || cmp_we_hi) begin
        if (cmp_we_lo) compare_q[31:0]  <= wdata;
        if (cmp_we_hi) compare_q[63:32] <= wdata;
      end else if (reload) begin
        compare_q <= compare_q + period;
      end
    end
  end

  assign compare    = compare_q;
  assign intr_state = state_q;

endmodule

// File: rtl/rv_timer_multi.sv
// Multi-channel RISC-V timer: prescaled 64-bit mtime shared by NumTimers comparator channels behind a
// register port. Optional compare autoreload: RV_TIMER_MULTI_AUTORELOAD_EN.
module rv_timer_multi #(
  parameter int unsigned NumTimers = 4,
  parameter int unsigned PrescaleW = 12,
  parameter int unsigned StepW     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [11:0]          reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_err_o,
  output logic [NumTimers-1:0] intr_o
);
  import rv_timer_multi_pkg::*;

  localparam logic [CFG_PRESCALE_W-1:0] PrescaleMask = CFG_PRESCALE_W'((64'd1 << PrescaleW) - 64'd1);
  localparam logic [CFG_STEP_W-1:0]     StepMask     = CFG_STEP_W'((64'd1 << StepW) - 64'd1);

  cfg_t                      cfg_q;
  logic [CFG_PRESCALE_W-1:0] pcnt_q;
  logic [63:0]               mtime_q;
  logic [NumTimers-1:0]      intr_enable_q;
  logic [NumTimers-1:0]      intr_state;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic                      tick;

  logic                      wr_en;
  logic                      aligned;
  logic [3:0]                page;
  logic [4:0]                idx;
  logic                      half_hi;
  logic                      chan_ok;
  logic                      ctrl_we, cfg_we, mlo_we, mhi_we, en_we, st_we, test_we;
  logic [NumTimers-1:0]      cmp_we_lo, cmp_we_hi, prd_we_lo, prd_we_hi;
  logic [63:0]               cmp_all [NumTimers];
  logic [63:0]               prd_all [NumTimers];
  logic [63:0]               cmp_pad [32];
  logic [63:0]               prd_pad [32];
  logic [31:0]               rdata_d;
  logic                      err_d;

  assign wr_en   = reg_req_i & reg_we_i;
  assign aligned = (reg_addr_i[1:0] == 2'b00);
  assign page    = reg_addr_i[11:8];
  assign idx     = reg_addr_i[7:3];
  assign half_hi = reg_addr_i[2];
  assign chan_ok = aligned && (32'(idx) < NumTimers);

  assign ctrl_we = wr_en && (reg_addr_i == REG_CTRL);
  assign cfg_we  = wr_en && (reg_addr_i == REG_CFG);
  assign mlo_we  = wr_en && (reg_addr_i == REG_MTIME_LO);
  assign mhi_we  = wr_en && (reg_addr_i == REG_MTIME_HI);
  assign en_we   = wr_en && (reg_addr_i == REG_INTR_ENABLE);
  assign st_we   = wr_en && (reg_addr_i == REG_INTR_STATE);
  assign test_we = wr_en && (reg_addr_i == REG_INTR_TEST);

  always_comb begin
    cmp_we_lo = '0;
    cmp_we_hi = '0;
    prd_we_lo = '0;
    prd_we_hi = '0;
    for (int unsigned i = 0; i < NumTimers; i++) begin
      if (wr_en && chan_ok && (idx == 5'(i))) begin
        cmp_we_lo[i] = (page == CMP_PAGE) && !half_hi;
        cmp_we_hi[i] = (page == CMP_PAGE) &&  half_hi;
        prd_we_lo[i] = (page == PRD_PAGE) && !half_hi;
        prd_we_hi[i] = (page == PRD_PAGE) &&  half_hi;
      end
    end
  end

  for (genvar g = 0; g < NumTimers; g++) begin : g_chan
    rv_timer_multi_chan u_chan (
      .clk        (clk_i),
      .rst        (rst_i),
      .mtime      (mtime_q),
      .cmp_we_lo  (cmp_we_lo[g]),
      .cmp_we_hi  (cmp_we_hi[g]),
      .prd_we_lo  (prd_we_lo[g]),
      .prd_we_hi  (prd_we_hi[g]),
      .wdata      (reg_wdata_i),
      .set_test   (test_we & reg_wdata_i[g]),
      .clr        (st_we & reg_wdata_i[g]),
      .compare    (cmp_all[g]),
      .period     (prd_all[g]),
      .intr_state (intr_state[g])
    );
  end

  // Pad channel arrays to the full 5-bit index range so the read mux never indexes out of bounds
  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      cmp_pad[i] = '0;
      prd_pad[i] = '0;
    end
    for (int unsigned i = 0; i < NumTimers; i++) begin
      cmp_pad[i] = cmp_all[i];
      prd_pad[i] = prd_all[i];
    end
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (!aligned) begin
      err_d = 1'b1;
    end else if ((page == CMP_PAGE) || (page == PRD_PAGE)) begin
      if (!chan_ok) begin
        err_d = 1'b1;
      end else if (page == CMP_PAGE) begin
        rdata_d = half_hi ? cmp_pad[idx][63:32] : cmp_pad[idx][31:0];
      end else begin
        rdata_d = half_hi ? prd_pad[idx][63:32] : prd_pad[idx][31:0];
      end
    end else begin
      case (reg_addr_i)
        REG_CTRL:        rdata_d = {31'b0, cfg_q.active};
        REG_CFG:         rdata_d = cfg_to_word(cfg_q);
        REG_MTIME_LO:    rdata_d = mtime_q[31:0];
        REG_MTIME_HI:    rdata_d = mtime_q[63:32];
        REG_INTR_ENABLE: rdata_d = 32'(intr_enable_q);
        REG_INTR_STATE:  rdata_d = 32'(intr_state);
        REG_INTR_TEST:   rdata_d = '0;
        default:         err_d   = 1'b1;
      endcase
    end
  end

  assign tick = cfg_q.active && (pcnt_q >= cfg_q.prescale);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q         <= '0;
      pcnt_q        <= '0;
      mtime_q       <= '0;
      intr_enable_q <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      rvalid_q <= reg_req_i;
      rdata_q  <= (reg_req_i && !reg_we_i) ? rdata_d : '0;
      err_q    <= reg_req_i && err_d;

      if (ctrl_we) cfg_q.active <= reg_wdata_i[CTRL_ACTIVE_BIT];
      if (cfg_we) begin
        cfg_q.prescale <= reg_wdata_i[CFG_PRESCALE_LSB +: CFG_PRESCALE_W] & PrescaleMask;
        cfg_q.step     <= reg_wdata_i[CFG_STEP_LSB +: CFG_STEP_W] & StepMask;
      end
      if (en_we) intr_enable_q <= reg_wdata_i[NumTimers-1:0];

      if (cfg_q.active) pcnt_q <= tick ? '0 : pcnt_q + 1'b1;

      // A software write to either half suppresses the tick for the whole counter
      if (mlo_we || mhi_we) begin
        if (mlo_we) mtime_q[31:0]  <= reg_wdata_i;
        if (mhi_we) mtime_q[63:32] <= reg_wdata_i;
      end else if (tick) begin
        mtime_q <= mtime_q + 64'(cfg_q.step);
      end
    end
  end

  assign intr_o       = intr_state & intr_enable_q;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;

endmodule

// File: tb/tb_rv_timer_multi.sv
// Directed bench for rv_timer_multi: hand-computed register/interrupt expectations on a 4-channel and
// a 1-channel instance sharing one register port.
module tb_rv_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        rvalid,  rvalid1;
  logic [31:0] rdata,   rdata1;
  logic        err,     err1;
  logic [3:0]  intr;
  logic [0:0]  intr1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rd_data, rd1_data;
  logic        rd_err,  rd1_err, rd1_valid;

  rv_timer_multi #(.NumTimers(4), .PrescaleW(12), .StepW(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata), .reg_err_o(err), .intr_o(intr)
  );

  rv_timer_multi #(.NumTimers(1), .PrescaleW(12), .StepW(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_rvalid_o(rvalid1), .reg_rdata_o(rdata1), .reg_err_o(err1), .intr_o(intr1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a negedge; the request is sampled by the posedge in between
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    chk("rvalid", rvalid, 1);
    rd_data   = rdata;
    rd_err    = err;
    rd1_data  = rdata1;
    rd1_err   = err1;
    rd1_valid = rvalid1;
    req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_err);
    rd(a);
    chk(tag, rd_data, exp);
    chk({tag, "_err"}, rd_err, exp_err);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_intr", intr, 0);
    chk("rst_intr1", intr1, 0);
    rst = 1'b0;
    rd_chk("rst_ctrl", 12'h000, 32'h0, 1'b0);
    rd_chk("rst_cfg", 12'h004, 32'h0, 1'b0);
    rd_chk("rst_mtime_lo", 12'h008, 32'h0, 1'b0);
    rd_chk("rst_cmp0_hi", 12'h104, 32'hFFFF_FFFF, 1'b0);
    rd_chk("rst_cmp3_lo", 12'h118, 32'hFFFF_FFFF, 1'b0);
    rd_chk("rst_enable", 12'h010, 32'h0, 1'b0);

    // 1: prescale 0, step 1, compare0 = 10
    wr(12'h004, 32'h0001_0000);
    wr(12'h100, 32'd10);
    wr(12'h104, 32'd0);
    wr(12'h010, 32'h1);
    wr(12'h000, 32'h1);
    repeat (9) @(negedge clk);
    chk("t1_intr_m9", intr, 4'h0);
    @(negedge clk);
    chk("t1_intr_m10", intr, 4'h0);
    @(negedge clk);
    chk("t1_intr_m11", intr, 4'h1);
    rd_chk("t1_mtime_rd", 12'h008, 32'd11, 1'b0);
    wr(12'h000, 32'h0);
    rd_chk("t1_mtime_frozen", 12'h008, 32'd13, 1'b0);
    rd_chk("t1_mtime_hi", 12'h00C, 32'd0, 1'b0);

    // 2: prescale 3, step 2; freeze mid-count and resume
    wr(12'h008, 32'd0);
    wr(12'h004, 32'h0002_0003);
    rd_chk("t2_cfg", 12'h004, 32'h0002_0003, 1'b0);
    wr(12'h000, 32'h1);
    repeat (5) @(negedge clk);
    wr(12'h000, 32'h0);
    repeat (4) @(negedge clk);
    rd_chk("t2_frozen", 12'h008, 32'd2, 1'b0);
    wr(12'h000, 32'h1);
    repeat (2) @(negedge clk);
    rd_chk("t2_pcnt_kept", 12'h008, 32'd4, 1'b0);
    wr(12'h000, 32'h0);

    // 3: wrap from 2^64-2 with step 4; state set at all-ones stays set
    wr(12'h004, 32'h0004_0000);
    wr(12'h00C, 32'hFFFF_FFFF);
    wr(12'h008, 32'hFFFF_FFFF);
    wr(12'h008, 32'hFFFF_FFFE);
    wr(12'h000, 32'h1);
    wr(12'h000, 32'h0);
    rd_chk("t3_wrap_lo", 12'h008, 32'd2, 1'b0);
    rd_chk("t3_wrap_hi", 12'h00C, 32'd0, 1'b0);
    rd_chk("t3_state", 12'h014, 32'hF, 1'b0);
    chk("t3_intr", intr, 4'h1);

    // 4: W1C while expired keeps the bit; after moving compare above mtime it clears
    wr(12'h100, 32'd0);
    wr(12'h014, 32'hF);
    rd_chk("t4_w1c_expired", 12'h014, 32'h1, 1'b0);
    wr(12'h104, 32'd1);
    wr(12'h014, 32'h1);
    rd_chk("t4_w1c_clear", 12'h014, 32'h0, 1'b0);
    chk("t4_intr", intr, 4'h0);

    // 5: INTR_TEST with enable masking
    wr(12'h010, 32'h0);
    wr(12'h018, 32'h5);
    chk("t5_intr_masked", intr, 4'h0);
    rd_chk("t5_state", 12'h014, 32'h5, 1'b0);
    rd_chk("t5_test_rd0", 12'h018, 32'h0, 1'b0);
    wr(12'h010, 32'hF);
    chk("t5_intr_en", intr, 4'h5);
    wr(12'h014, 32'hF);
    rd_chk("t5_cleared", 12'h014, 32'h0, 1'b0);

    // 6: period registers
`ifdef RV_TIMER_MULTI_AUTORELOAD_EN
    wr(12'h004, 32'h0001_0000);
    wr(12'h008, 32'd0);
    wr(12'h10C, 32'd0);
    wr(12'h108, 32'd100);
    wr(12'h208, 32'd50);
    wr(12'h20C, 32'd0);
    rd_chk("t6_period_lo", 12'h208, 32'd50, 1'b0);
    wr(12'h000, 32'h1);
    repeat (100) @(negedge clk);
    chk("t6_intr_pre100", intr, 4'h0);
    @(negedge clk);
    chk("t6_intr_at100", intr, 4'h2);
    rd_chk("t6_reload150", 12'h108, 32'd150, 1'b0);
    wr(12'h014, 32'h2);
    repeat (47) @(negedge clk);
    chk("t6_intr_pre150", intr, 4'h0);
    @(negedge clk);
    chk("t6_intr_at150", intr, 4'h2);
    wr(12'h000, 32'h0);
    rd_chk("t6_reload200", 12'h108, 32'd200, 1'b0);
`else
    wr(12'h208, 32'd50);
    rd_chk("t6_period_ro", 12'h208, 32'd0, 1'b0);
    rd_chk("t6_cmp1_kept", 12'h108, 32'hFFFF_FFFF, 1'b0);
`endif

    // 7: unmapped, misaligned and out-of-range channel accesses
    rd_chk("t7_unmapped", 12'h020, 32'h0, 1'b1);
    rd_chk("t7_misaligned", 12'h002, 32'h0, 1'b1);
    rd_chk("t7_chan4", 12'h120, 32'h0, 1'b1);
    rd(12'h108);
    chk("t7_n4_cmp1_err", rd_err, 0);
    chk("t7_n1_valid", rd1_valid, 1);
    chk("t7_n1_cmp1_err", rd1_err, 1);
    chk("t7_n1_cmp1_data", rd1_data, 0);

    // Reset mid-operation drops the pending response and restores reset values
    wr(12'h018, 32'h3);
    wr(12'h000, 32'h1);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 12'h000;
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_intr", intr, 4'h0);
    rst = 1'b0; req = 1'b0;
    rd_chk("mid_rst_ctrl", 12'h000, 32'h0, 1'b0);
    rd_chk("mid_rst_mtime", 12'h008, 32'h0, 1'b0);
    rd_chk("mid_rst_cmp0", 12'h100, 32'hFFFF_FFFF, 1'b0);
    rd_chk("mid_rst_state", 12'h014, 32'h0, 1'b0);
    rd_chk("mid_rst_enable", 12'h010, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
